ipm2l_hsstlp_pll_lock_model_v1_0: RTL

//  Synthesizable responder for the HSST PLL reset/lock handshake. Consumes P_PLLPOWERDOWN/P_PLL_RST from
//  ipm2l_hsstlp_pll_rst_fsm_v1_0 and returns P_PLL_READY with programmable power-up and lock timing.

---
 rtl/ipm2l_hsstlp_pll_lock_model_v1_0_pkg.sv | 26 ++
 rtl/ipm2l_hsstlp_pll_glitch_gen_v1_0.sv | 36 +++
 rtl/ipm2l_hsstlp_pll_lock_model_v1_0.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ipm2l_hsstlp_pll_lock_model_v1_0_pkg.sv
// Purpose: state encodings and glitch-generator constants shared by the PLL lock model.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ipm2l_hsstlp_pll_lock_model_v1_0_pkg;

    // FSM state encodings; the numeric values are visible on o_state
    typedef enum logic [2:0] {
        PLL_ST_PD     = 3'd0,
        PLL_ST_PWRUP  = 3'd1,
        PLL_ST_RST    = 3'd2,
        PLL_ST_ACQ    = 3'd3,
        PLL_ST_LOCKED = 3'd4,
        PLL_ST_LOSS   = 3'd5
    } pll_state_e;

    // Lock-debounce glitch train: window length, pulse period and pulse width in clk cycles
    localparam int GLITCH_WIN = 64;
    localparam int GLITCH_PER = 16;
    localparam int GLITCH_W   = 4;

    // True for the first GLITCH_W cycles of each GLITCH_PER period
    function automatic logic glitch_phase_on(input logic [5:0] offset);
        return (offset % 6'(GLITCH_PER)) < 6'(GLITCH_W);
    endfunction

endpackage

// File: rtl/ipm2l_hsstlp_pll_glitch_gen_v1_0.sv
// Purpose: false-lock pulse train during the first GLITCH_WIN cycles of each ACQ visit (PLL_LOCK_MODEL_GLITCH_EN only).
// Latency: glitch_out is high in the first cycle en is high; pulses at offsets 0,16,32,48, GLITCH_W cycles each.
// Backpressure: none; free-running once en rises, restarts on every new rising edge of en.
`ifdef PLL_LOCK_MODEL_GLITCH_EN
module ipm2l_hsstlp_pll_glitch_gen_v1_0
    import ipm2l_hsstlp_pll_lock_model_v1_0_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic glitch_out
);

    logic [5:0] offset_q;
    logic       done_q;

    // Offset within the current en window; held at zero while en is low so it restarts when en rises
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            offset_q <= '0;
            done_q   <= 1'b0;
        end else if (!en) begin
            offset_q <= '0;
            done_q   <= 1'b0;
        end else if (!done_q) begin
            if (offset_q == 6'(GLITCH_WIN - 1)) begin
                done_q <= 1'b1;
            end
            offset_q <= offset_q + 6'd1;
        end
    end

    assign glitch_out = en && !done_q && glitch_phase_on(offset_q);

endmodule
`endif

// File: rtl/ipm2l_hsstlp_pll_lock_model_v1_0.sv
// Purpose: behavioural-but-synthesizable stand-in for the HSST PLL power-up / reset / lock handshake.
// Latency: READY rises LOCK_CYCLES edges after the first edge sampling P_PLL_RST=0; all outputs registered.
// Backpressure: none; P_PLLPOWERDOWN overrides everything. Macro PLL_LOCK_MODEL_GLITCH_EN adds ACQ false-lock pulses.
module ipm2l_hsstlp_pll_lock_model_v1_0
    import ipm2l_hsstlp_pll_lock_model_v1_0_pkg::*;
#(
    parameter int POWERUP_CYCLES = 256,
    parameter int LOCK_CYCLES    = 4096,
    parameter int RST_MIN_CYCLES = 64,
    parameter int LOSS_CYCLES    = 32,
    parameter int CNT_WIDTH      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       P_PLLPOWERDOWN,
    input  logic       P_PLL_RST,
    input  logic       i_lock_loss,
    input  logic       i_lock_hold,
    output logic       P_PLL_READY,
    output logic [2:0] o_state,
    output logic       o_err_seq,
    output logic       o_err_rst_width
);

    localparam logic [CNT_WIDTH-1:0] PWRUP_LOAD = CNT_WIDTH'(POWERUP_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] LOCK_LOAD  = CNT_WIDTH'(LOCK_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] LOSS_LOAD  = CNT_WIDTH'(LOSS_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] RST_MIN    = CNT_WIDTH'(RST_MIN_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    pll_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;      // shared down-counter: power-up, lock and loss timing
    logic [CNT_WIDTH-1:0] wcnt_q, wcnt_d;    // P_PLL_RST high width, saturating at RST_MIN
    logic                 wchk_q, wchk_d;    // current RST visit is a fresh pulse whose width is checked
    logic                 ready_q, ready_d;
    logic                 err_seq_q, err_seq_d;
    logic                 err_w_q, err_w_d;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= PLL_ST_PD;
            cnt_q     <= '0;
            wcnt_q    <= '0;
            wchk_q    <= 1'b0;
            ready_q   <= 1'b0;
            err_seq_q <= 1'b0;
            err_w_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wcnt_q    <= wcnt_d;
            wchk_q    <= wchk_d;
            ready_q   <= ready_d;
            err_seq_q <= err_seq_d;
            err_w_q   <= err_w_d;
        end
    end

    // Next-state, counter and flag logic; priority PD > P_PLL_RST > i_lock_loss > counter expiry
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wcnt_d    = wcnt_q;
        wchk_d    = wchk_q;
        ready_d   = ready_q;
        err_seq_d = err_seq_q;
        err_w_d   = err_w_q;

        if (P_PLLPOWERDOWN) begin
            state_d = PLL_ST_PD;
            cnt_d   = CNT_ZERO;
            ready_d = 1'b0;
        end else begin
            unique case (state_q)
                PLL_ST_PD: begin
                    state_d = PLL_ST_PWRUP;
                    cnt_d   = PWRUP_LOAD;
                    ready_d = 1'b0;
                    // The controller must hold the PLL in reset while releasing power-down
                    if (!P_PLL_RST) begin
                        err_seq_d = 1'b1;
                    end
                end

                PLL_ST_PWRUP: begin
                    ready_d = 1'b0;
                    if (cnt_q == CNT_ZERO) begin
                        if (P_PLL_RST) begin
                            // Reset held across power-up already spans the whole PWRUP time,
                            // so only pulses raised after power-up are width-checked
                            state_d = PLL_ST_RST;
                            wcnt_d  = CNT_ZERO;
                            wchk_d  = 1'b0;
                        end else begin
                            state_d = PLL_ST_ACQ;
                            cnt_d   = LOCK_LOAD;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end

                PLL_ST_RST: begin
                    ready_d = 1'b0;
                    if (!P_PLL_RST) begin
                        state_d = PLL_ST_ACQ;
                        cnt_d   = LOCK_LOAD;
                        if (wchk_q && (wcnt_q < RST_MIN)) begin
                            err_w_d = 1'b1;
                        end
                    end else if (wcnt_q < RST_MIN) begin
                        wcnt_d = wcnt_q + CNT_ONE;
                    end
                end

                PLL_ST_ACQ: begin
                    ready_d = 1'b0;
                    if (P_PLL_RST) begin
                        state_d = PLL_ST_RST;
                        wcnt_d  = CNT_ZERO;
                        wchk_d  = 1'b1;
                    end else if (cnt_q == CNT_ZERO) begin
                        state_d = PLL_ST_LOCKED;
                        ready_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end

                PLL_ST_LOCKED: begin
                    ready_d = 1'b1;
                    if (P_PLL_RST) begin
                        state_d = PLL_ST_RST;
                        ready_d = 1'b0;
                        wcnt_d  = CNT_ZERO;
                        wchk_d  = 1'b1;
                    end else if (i_lock_loss) begin
                        state_d = PLL_ST_LOSS;
                        ready_d = 1'b0;
                        cnt_d   = LOSS_LOAD;
                    end
                end

                PLL_ST_LOSS: begin
                    ready_d = 1'b0;
                    if (P_PLL_RST) begin
                        state_d = PLL_ST_RST;
                        wcnt_d  = CNT_ZERO;
                        wchk_d  = 1'b1;
                    end else if (cnt_q == CNT_ZERO) begin
                        // Parked at zero while the hold is asserted
                        if (!i_lock_hold) begin
                            state_d = PLL_ST_ACQ;
                            cnt_d   = LOCK_LOAD;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end

                default: begin
                    state_d = PLL_ST_PD;
                    cnt_d   = CNT_ZERO;
                    ready_d = 1'b0;
                end
            endcase
        end
    end

    assign o_state         = state_q;
    assign o_err_seq       = err_seq_q;
    assign o_err_rst_width = err_w_q;

`ifdef PLL_LOCK_MODEL_GLITCH_EN
    logic acq_en;
    logic glitch;

    assign acq_en = (state_q == PLL_ST_ACQ);

    ipm2l_hsstlp_pll_glitch_gen_v1_0 u_glitch_gen (
        .clk        (clk),
        .rst        (rst),
        .en         (acq_en),
        .glitch_out (glitch)
    );

    assign P_PLL_READY = ready_q | glitch;
`else
    assign P_PLL_READY = ready_q;
`endif

endmodule
